// File: rtl/ram_pkg.sv
// Shared constants, helper function and clear-FSM state type for the
// simple-dual-port RAM.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_clr_state_t;

  function automatic int clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return int'(r);
  endfunction

endpackage

// File: rtl/ram_sdp_clear_ctrl.sv
// Post-reset clear sweep: walks every address once, holding busy high until
// the last word has been written.
module ram_sdp_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  ram_clr_state_t        state;
  logic [ADDR_WIDTH-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + ADDR_WIDTH'(1);
          if (ptr == LAST) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_READY: begin
          ptr <= ptr;
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/ram_sdp_sync.sv
// Synchronous simple-dual-port RAM with byte-lane writes, selectable
// read-during-write policy and a clear sweep after reset.
// Define RAM_SDP_OREG_EN to add an output pipeline register (2-cycle reads).
module ram_sdp_sync
  import ram_pkg::*;
#(
  parameter int                     DATA_WIDTH  = 8,
  parameter int                     ADDR_WIDTH  = 3,
  parameter int                     BYTE_WIDTH  = 8,
  parameter int                     RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             rvalid,
  output logic                             busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rv_q;

  ram_sdp_clear_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // New-data mode forwards enabled write lanes; otherwise the array's
  // pre-edge contents are the old data.
  always_comb begin
    rd_word = mem[raddr];
    if (RDW_MODE == RDW_NEW && we && waddr == raddr) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem[clr_addr] <= CLEAR_VALUE;
      end else if (we) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wbe[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else if (re && !busy) begin
      rd_q <= rd_word;
      rv_q <= 1'b1;
    end else begin
      rv_q <= 1'b0;
    end
  end

`ifdef RAM_SDP_OREG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rv_q;
      if (rv_q) rdata <= rd_q;
    end
  end
`else
  assign rdata  = rd_q;
  assign rvalid = rv_q;
`endif

endmodule
